mcycle_unit: RTL and testbench
==============================

// Module: mcycle_unit
// PURPOSE
//  Parametrised multi-cycle multiply/divide unit serving the decoder's MUL/DIV path.
//  Accepts a one-cycle Start with MCycleOp and two operands.
//  Computes the full 2*WIDTH product, or quotient and remainder, one bit per cycle.
//  Returns results with a one-cycle Done pulse; the decoder gates register write-back on that pulse.
//  Generalises the fixed 32-bit unsigned unit with these additions:
//   - width parameter; signed and unsigned modes
//   - divide-by-zero fast path; Abort (pipeline flush)
// PARAMETERS
//  WIDTH      32   operand width in bits (>=4); products are 2*WIDTH wide
//  DIV0_FAST  1    1: divide-by-zero completes in 1 cycle; 0: runs the full WIDTH iterations
// PORTS
//  CLK        in   1      clock, rising edge
//  RESET_n    in   1      asynchronous, active-low reset
//  Start      in   1      launch request; sampled when the unit is not Busy
//  MCycleOp   in   2      00 signed MUL, 01 unsigned MUL, 10 signed DIV, 11 unsigned DIV
//  Operand1   in   WIDTH  multiplicand / dividend
//  Operand2   in   WIDTH  multiplier / divisor
//  Abort      in   1      cancel the in-flight operation (flush)
//  Result1    out  WIDTH  product low half / quotient
//  Result2    out  WIDTH  product high half / remainder
//  Busy       out  1      operation in progress (RUN state)
//  Done       out  1      one-cycle pulse: Result1/Result2 valid from this cycle
// BEHAVIOUR
//  Reset (RESET_n=0, async): state IDLE; Busy=0, Done=0, Result1=Result2=0; counter and datapath cleared.
//   Reset mid-operation discards the operation; no Done is produced.
//  States: IDLE -> RUN -> DONE -> IDLE.
//   Busy=1 only in RUN; Done=1 only in DONE.
//  Launch: rising edge t0 with Start=1 in IDLE or DONE (back-to-back allowed) and Abort=0.
//   Latches op and operands; enters RUN.
//   Signed ops convert operands to magnitudes at launch and record the result signs.
//  Start while Busy=1: ignored; the in-flight op and its inputs are unaffected.
//  RUN: counter runs WIDTH iterations, one bit each.
//   MUL: shift-add over a 2*WIDTH accumulator.
//   DIV: restoring division over a WIDTH+1-bit partial remainder.
//   After the last iteration the unit enters DONE.
//   DONE: Done=1; results registered with signs applied.
//   Latency: Done high in cycle t0+WIDTH+1.
//  DONE lasts exactly one cycle, then IDLE; Start in the DONE cycle launches a new op.
//  Result1/Result2 hold their value until the next Done; they are not updated during RUN.
//  Signed MUL: {Result2,Result1} = two's-complement 2*WIDTH product.
//  Signed DIV: quotient truncates toward zero.
//   Quotient sign = sign(Op1) XOR sign(Op2); remainder takes the dividend's sign.
//   -2^(WIDTH-1) / -1 gives quotient -2^(WIDTH-1) (wraps) and remainder 0; no flag.
//  Divide by zero (Operand2=0, DIV op): Result1 = all ones, Result2 = Operand1 unmodified (signed or unsigned).
//   DIV0_FAST=1: skips RUN, so Done is in cycle t0+1 and Busy never asserts.
//  Abort=1 in RUN: the next state is IDLE and Done is not asserted.
//   Results are unchanged; the counter is cleared.
//   Abort with Start in the same cycle: Abort wins and no launch occurs.
//   Abort in IDLE or DONE has no effect on the Done pulse already in progress.
//  Outputs are purely registered; there is no combinational path from inputs to Busy, Done or Result*.
// TESTING (WIDTH=32, DIV0_FAST=1)
//  1 Signed MUL -3 x 7:
//    -> Done at t0+33; Result2=0xFFFFFFFF, Result1=0xFFFFFFEB; Busy high t0+1..t0+32.
//  2 Unsigned MUL 0xFFFFFFFF x 0xFFFFFFFF:
//    -> Result2=0xFFFFFFFE, Result1=0x00000001; then Start in the DONE cycle launches a second op, Done at +33 again.
//  3 Signed DIV -7 / 2:
//    -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF.
//    Also 0x80000000 / 0xFFFFFFFF -> Result1=0x80000000, Result2=0.
//  4 Unsigned DIV 100 / 0:
//    -> Done at t0+1, Busy stays 0, Result1=0xFFFFFFFF, Result2=100.
//  5 Unsigned DIV 1000/3 with Abort at t0+10:
//    -> Busy falls at t0+11, no Done; Result* keep prior values; Start toggled at t0+5 is ignored.
//  6 RESET_n low mid-RUN (asynchronous, between edges):
//    -> Busy, Done and Result* go to 0 immediately; no Done after release.

Source files
------------

// File: rtl/mcycle_unit_if.sv
// Handshake and result bundle between the decoder's MUL/DIV path and mcycle_unit.
// master = decoder side, slave = the unit.
interface mcycle_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       MCycleOp;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic             Abort;
  logic [WIDTH-1:0] Result1;
  logic [WIDTH-1:0] Result2;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, MCycleOp, Operand1, Operand2, Abort,
    input  Result1, Result2, Busy, Done
  );

  modport slave (
    input  Start, MCycleOp, Operand1, Operand2, Abort,
    output Result1, Result2, Busy, Done
  );
endinterface

// File: rtl/mcycle_unit.sv
// Multi-cycle signed/unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
// Operands are reduced to magnitudes at launch; signs are applied when results are registered.
module mcycle_unit #(
  parameter int WIDTH     = 32,
  parameter bit DIV0_FAST = 1'b1
) (
  input logic         CLK,
  input logic         RESET_n,
  mcycle_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               negp_q, negp_d;
  logic               negr_q, negr_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   res1_q, res1_d;
  logic [WIDTH-1:0]   res2_q, res2_d;

  logic               launch;
  logic               sgn_mode;
  logic               s1, s2;
  logic               div0;
  logic [WIDTH-1:0]   mag1, mag2;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_qbit;
  logic [2*WIDTH-1:0] div_acc;
  logic [WIDTH-1:0]   div_rem;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fin1, fin2;

  // Launch-time operand conditioning
  always_comb begin
    launch   = (state_q != S_RUN) && bus.Start && !bus.Abort;
    sgn_mode = !bus.MCycleOp[0];
    s1       = sgn_mode && bus.Operand1[WIDTH-1];
    s2       = sgn_mode && bus.Operand2[WIDTH-1];
    mag1     = s1 ? (~bus.Operand1 + WIDTH'(1)) : bus.Operand1;
    mag2     = s2 ? (~bus.Operand2 + WIDTH'(1)) : bus.Operand2;
    div0     = bus.MCycleOp[1] && (bus.Operand2 == '0);
  end

  // One iteration of each datapath plus sign application on the final step
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : '0)};
    mul_acc   = {mul_sum, acc_q[WIDTH-1:1]};

    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    div_qbit  = !div_diff[WIDTH];
    div_rem   = div_qbit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_acc   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_qbit};

    prod_s    = negp_q ? (~mul_acc + (2*WIDTH)'(1)) : mul_acc;
    if (is_div_q) begin
      fin1 = negp_q ? (~div_acc[WIDTH-1:0] + WIDTH'(1)) : div_acc[WIDTH-1:0];
      fin2 = negr_q ? (~div_rem + WIDTH'(1)) : div_rem;
    end else begin
      fin1 = prod_s[WIDTH-1:0];
      fin2 = prod_s[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    negp_d   = negp_q;
    negr_d   = negr_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opb_d    = opb_q;
    res1_d   = res1_q;
    res2_d   = res2_q;

    case (state_q)
      S_RUN: begin
        if (bus.Abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = is_div_q ? div_acc : mul_acc;
          rem_d = is_div_q ? div_rem : rem_q;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = S_DONE;
            cnt_d   = '0;
            res1_d  = fin1;
            res2_d  = fin2;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        if (launch) begin
          is_div_d = bus.MCycleOp[1];
          // Divide-by-zero keeps the quotient unsigned all-ones; the remainder sign
          // restores the raw dividend from its magnitude.
          negp_d   = (s1 ^ s2) && !div0;
          negr_d   = s1;
          cnt_d    = CNT_LAST;
          rem_d    = '0;
          if (bus.MCycleOp[1]) begin
            acc_d = {{WIDTH{1'b0}}, mag1};
            opb_d = mag2;
          end else begin
            acc_d = {{WIDTH{1'b0}}, mag2};
            opb_d = mag1;
          end
          if (div0 && DIV0_FAST) begin
            state_d = S_DONE;
            cnt_d   = '0;
            res1_d  = '1;
            res2_d  = bus.Operand1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      negp_q   <= 1'b0;
      negr_q   <= 1'b0;
      acc_q    <= '0;
      rem_q    <= '0;
      opb_q    <= '0;
      res1_q   <= '0;
      res2_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      negp_q   <= negp_d;
      negr_q   <= negr_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opb_q    <= opb_d;
      res1_q   <= res1_d;
      res2_q   <= res2_d;
    end
  end

  assign bus.Busy    = (state_q == S_RUN);
  assign bus.Done    = (state_q == S_DONE);
  assign bus.Result1 = res1_q;
  assign bus.Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed bench for mcycle_unit at WIDTH=32, DIV0_FAST=1; inputs driven and outputs sampled on negedge.
module tb_mcycle_unit;

  localparam int W = 32;

  logic CLK;
  logic RESET_n;
  int   tests;
  int   fails;
  int   cyc;
  int   busy_cnt;
  int   done_seen;

  mcycle_unit_if #(.WIDTH(W)) bus ();

  mcycle_unit #(.WIDTH(W), .DIV0_FAST(1'b1)) dut (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start is sampled at the next posedge (t0); on return the bench sits in cycle t0+1.
  task automatic launch(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.Start    = 1'b1;
    bus.MCycleOp = op;
    bus.Operand1 = a;
    bus.Operand2 = b;
    @(negedge CLK);
    bus.Start    = 1'b0;
  endtask

  task automatic wait_done(input int start, output int c, output int nbusy);
    c     = start;
    nbusy = 0;
    while (!bus.Done && c < 100) begin
      if (bus.Busy) nbusy++;
      @(negedge CLK);
      c++;
    end
    tests++;
    if (!bus.Done) begin
      fails++;
      $error("FAIL wait_done: Done not seen by cycle %0d", c);
    end
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    RESET_n      = 1'b0;
    bus.Start    = 1'b0;
    bus.MCycleOp = 2'b00;
    bus.Operand1 = '0;
    bus.Operand2 = '0;
    bus.Abort    = 1'b0;
    #12;
    chk("rst_busy", bus.Busy, 1'b0);
    chk("rst_done", bus.Done, 1'b0);
    chk("rst_r1", bus.Result1, 32'h0);
    chk("rst_r2", bus.Result2, 32'h0);
    @(negedge CLK);
    RESET_n = 1'b1;
    @(negedge CLK);

    // 1: signed MUL -3 x 7
    launch(2'b00, 32'hFFFFFFFD, 32'd7);
    chk("t1_busy_t1", bus.Busy, 1'b1);
    wait_done(1, cyc, busy_cnt);
    chk("t1_latency", cyc, 33);
    chk("t1_busy_cycles", busy_cnt, 32);
    chk("t1_busy_in_done", bus.Busy, 1'b0);
    chk("t1_r2", bus.Result2, 32'hFFFFFFFF);
    chk("t1_r1", bus.Result1, 32'hFFFFFFEB);
    @(negedge CLK);
    chk("t1_done_one_cycle", bus.Done, 1'b0);
    chk("t1_hold_r1", bus.Result1, 32'hFFFFFFEB);

    // 2: unsigned MUL max x max, then back-to-back launch from the DONE cycle
    launch(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(1, cyc, busy_cnt);
    chk("t2_latency", cyc, 33);
    chk("t2_r2", bus.Result2, 32'hFFFFFFFE);
    chk("t2_r1", bus.Result1, 32'h00000001);
    launch(2'b01, 32'd12345, 32'd1000);
    chk("t2b_busy", bus.Busy, 1'b1);
    chk("t2b_hold_r2", bus.Result2, 32'hFFFFFFFE);
    wait_done(1, cyc, busy_cnt);
    chk("t2b_latency", cyc, 33);
    chk("t2b_r1", bus.Result1, 32'h00BC5EA8);
    chk("t2b_r2", bus.Result2, 32'h0);
    @(negedge CLK);

    // 3: signed DIV -7 / 2
    launch(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(1, cyc, busy_cnt);
    chk("t3_latency", cyc, 33);
    chk("t3_r1", bus.Result1, 32'hFFFFFFFD);
    chk("t3_r2", bus.Result2, 32'hFFFFFFFF);
    @(negedge CLK);

    // 3b: overflow case, with a Start pulse mid-run that must be ignored
    launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
    repeat (4) @(negedge CLK);
    bus.Start    = 1'b1;
    bus.MCycleOp = 2'b01;
    bus.Operand1 = 32'd5;
    bus.Operand2 = 32'd5;
    @(negedge CLK);
    bus.Start    = 1'b0;
    wait_done(6, cyc, busy_cnt);
    chk("t3b_latency", cyc, 33);
    chk("t3b_r1", bus.Result1, 32'h80000000);
    chk("t3b_r2", bus.Result2, 32'h0);
    @(negedge CLK);

    // 3c: signed DIV 7 / -2
    launch(2'b10, 32'd7, 32'hFFFFFFFE);
    wait_done(1, cyc, busy_cnt);
    chk("t3c_r1", bus.Result1, 32'hFFFFFFFD);
    chk("t3c_r2", bus.Result2, 32'd1);
    @(negedge CLK);

    // 4: unsigned DIV by zero, fast path
    launch(2'b11, 32'd100, 32'd0);
    chk("t4_done_t1", bus.Done, 1'b1);
    chk("t4_busy", bus.Busy, 1'b0);
    chk("t4_r1", bus.Result1, 32'hFFFFFFFF);
    chk("t4_r2", bus.Result2, 32'd100);
    @(negedge CLK);
    chk("t4_done_drop", bus.Done, 1'b0);

    // 4b: signed DIV by zero returns the raw dividend
    launch(2'b10, 32'hFFFFFF9C, 32'd0);
    chk("t4b_done_t1", bus.Done, 1'b1);
    chk("t4b_r1", bus.Result1, 32'hFFFFFFFF);
    chk("t4b_r2", bus.Result2, 32'hFFFFFF9C);
    @(negedge CLK);

    // 5: unsigned DIV 1000/3, Start at t0+5 ignored, Abort at t0+10
    launch(2'b11, 32'd1000, 32'd3);
    repeat (4) @(negedge CLK);
    bus.Start    = 1'b1;
    bus.Operand1 = 32'd9;
    @(negedge CLK);
    bus.Start    = 1'b0;
    chk("t5_busy_after_start", bus.Busy, 1'b1);
    repeat (4) @(negedge CLK);
    chk("t5_busy_t10", bus.Busy, 1'b1);
    bus.Abort = 1'b1;
    bus.Start = 1'b1;
    @(negedge CLK);
    bus.Abort = 1'b0;
    bus.Start = 1'b0;
    chk("t5_busy_t11", bus.Busy, 1'b0);
    done_seen = 0;
    repeat (40) begin
      if (bus.Done) done_seen++;
      if (bus.Busy) done_seen++;
      @(negedge CLK);
    end
    chk("t5_no_done", done_seen, 0);
    chk("t5_r1_kept", bus.Result1, 32'hFFFFFFFF);
    chk("t5_r2_kept", bus.Result2, 32'hFFFFFF9C);

    // 6: asynchronous reset mid-run
    launch(2'b01, 32'd3, 32'd5);
    repeat (5) @(negedge CLK);
    #2;
    RESET_n = 1'b0;
    #1;
    chk("t6_busy", bus.Busy, 1'b0);
    chk("t6_done", bus.Done, 1'b0);
    chk("t6_r1", bus.Result1, 32'h0);
    chk("t6_r2", bus.Result2, 32'h0);
    @(negedge CLK);
    RESET_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      if (bus.Done) done_seen++;
      @(negedge CLK);
    end
    chk("t6_no_done", done_seen, 0);

    // Post-reset sanity: unsigned DIV 1000/3
    launch(2'b11, 32'd1000, 32'd3);
    wait_done(1, cyc, busy_cnt);
    chk("t7_latency", cyc, 33);
    chk("t7_r1", bus.Result1, 32'd333);
    chk("t7_r2", bus.Result2, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
